// File: rtl/motoro3_sine_step_seq.sv
// Sine step sequencer: walks a 48-position electrical cycle at a programmable rate
// and emits the quarter-wave step index (1..12), quadrant, half-wave sign and pulses.
module motoro3_sine_step_seq #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             scEn,
   input  logic             scClr,
   input  logic             scDir,
   input  logic [DIV_W-1:0] scDiv,
   output logic [3:0]       scStep,
   output logic [1:0]       scQuad,
   output logic             scHalf,
   output logic             scTick,
   output logic             scCycle
);

   logic [5:0]       pos_q, pos_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             en_q;
   logic [3:0]       step_q, step_d;
   logic [1:0]       quad_q, quad_d;
   logic             tick_q, tick_d;
   logic             cyc_q, cyc_d;

   logic [5:0]       pos_adv;
   logic             wrap;
   logic [5:0]       dec_cur, dec_adv, dec_zero;

   // Returns {quadrant, step}; odd quadrants mirror so the peak and zero steps repeat.
   function automatic logic [5:0] decode(input logic [5:0] p);
      logic [1:0] q;
      logic [3:0] r;
      logic [3:0] s;
      if (p < 6'd12) begin
         q = 2'd0;
         r = p[3:0];
      end else if (p < 6'd24) begin
         q = 2'd1;
         r = 4'(p - 6'd12);
      end else if (p < 6'd36) begin
         q = 2'd2;
         r = 4'(p - 6'd24);
      end else begin
         q = 2'd3;
         r = 4'(p - 6'd36);
      end
      s = q[0] ? (4'd12 - r) : (r + 4'd1);
      return {q, s};
   endfunction

   always_comb begin
      if (scDir) begin
         wrap    = (pos_q == 6'd0);
         pos_adv = wrap ? 6'd47 : pos_q - 6'd1;
      end else begin
         wrap    = (pos_q == 6'd47);
         pos_adv = wrap ? 6'd0 : pos_q + 6'd1;
      end
   end

   assign dec_cur  = decode(pos_q);
   assign dec_adv  = decode(pos_adv);
   assign dec_zero = decode(6'd0);

   always_comb begin
      pos_d  = pos_q;
      cnt_d  = cnt_q;
      step_d = step_q;
      quad_d = quad_q;
      tick_d = 1'b0;
      cyc_d  = 1'b0;
      if (scClr) begin
         pos_d  = '0;
         cnt_d  = '0;
         quad_d = dec_zero[5:4];
         step_d = scEn ? dec_zero[3:0] : 4'd0;
      end else if (!scEn) begin
         step_d = 4'd0;
      end else if (!en_q) begin
         cnt_d            = '0;
         {quad_d, step_d} = dec_cur;
      end else if (cnt_q >= scDiv) begin
         // ">=" lets a shrunk divisor terminate at once instead of wrapping the counter
         cnt_d            = '0;
         pos_d            = pos_adv;
         {quad_d, step_d} = dec_adv;
         tick_d           = 1'b1;
         cyc_d            = wrap;
      end else begin
         cnt_d            = cnt_q + 1'b1;
         {quad_d, step_d} = dec_cur;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         pos_q  <= '0;
         cnt_q  <= '0;
         en_q   <= 1'b0;
         step_q <= '0;
         quad_q <= '0;
         tick_q <= 1'b0;
         cyc_q  <= 1'b0;
      end else begin
         pos_q  <= pos_d;
         cnt_q  <= cnt_d;
         en_q   <= scEn;
         step_q <= step_d;
         quad_q <= quad_d;
         tick_q <= tick_d;
         cyc_q  <= cyc_d;
      end
   end

   assign scStep  = step_q;
   assign scQuad  = quad_q;
   assign scHalf  = quad_q[1];
   assign scTick  = tick_q;
   assign scCycle = cyc_q;

endmodule

// File: doc/motoro3_sine_step_seq.md
Name: motoro3_sine_step_seq

Overview:
- Step sequencer that produces the 4-bit sine step index (1..12) consumed by the quarter-wave sine amplitude lookup.
- Walks a 48-position full electrical cycle at a programmable rate, in either direction.
- Mirrors the step index per quadrant and reports quadrant, half-wave sign, step tick and cycle-wrap pulses, so the downstream PWM stage can apply polarity.

Parameters:
DIV_W, 16, width of the prescaler divisor and counter.

Ports:
clk  input  1  system clock, rising edge
nRst  input  1  synchronous active-low reset
scEn  input  1  run enable; 0 = hold position, drive step 0
scClr  input  1  synchronous clear of position and prescaler
scDir  input  1  0 = forward (pos+1), 1 = reverse (pos-1)
scDiv  input  DIV_W  clocks per step minus 1
scStep  output  4  step index 1..12 to the amplitude lookup; 0 = zero amplitude
scQuad  output  2  quadrant 0..3 of current position
scHalf  output  1  0 = positive half-wave, 1 = negative (equals scQuad[1])
scTick  output  1  one-cycle pulse on each position advance
scCycle  output  1  one-cycle pulse on position wrap

Behaviour:
- Interface: one clock, clk; reset nRst is synchronous and active-low. All state changes on the rising edge of clk.
- Internal state: pos (6 bits, 0..47), cnt (DIV_W bits), enQ (registered scEn).
- Reset (nRst=0): pos=0, cnt=0, enQ=0. Outputs: scStep=0, scQuad=0, scHalf=0, scTick=0, scCycle=0.
- Decode of p, with q=p/12 and r=p%12:
  - scQuad = q; scHalf = q[1].
  - scStep = r+1 when q is even; scStep = 12-r when q is odd.
  - The peak (12) and zero-side (1) steps each appear twice consecutively. This is intentional: the table samples at half-step offsets.
- Priority per edge (nRst=1): scClr > scEn=0 > enable entry > run.
- scClr=1: pos=0, cnt=0. scTick=0, scCycle=0. scStep=decode(0) if scEn=1, else 0. Overrides a coincident terminal count.
- scEn=0: pos and cnt hold. scStep=0, scQuad and scHalf hold, scTick=0, scCycle=0.
- Enable entry (scEn=1, enQ=0): cnt=0, no advance. Outputs = decode(pos); scTick=0.
- Run (scEn=1, enQ=1):
  - If cnt>=scDiv: cnt=0; pos advances (forward 47->0, reverse 0->47); scTick=1; scCycle=1 only on a wrap.
  - Else: cnt=cnt+1, scTick=0, scCycle=0.
- Output timing:
  - scStep, scQuad and scHalf are registered and change on the same edge as pos, i.e. they equal decode of the new pos.
  - With scDiv=N, one step spans N+1 clocks. scDiv=0 advances every clock.
- scDiv changed mid-count: the ">=" compare terminates immediately if cnt already exceeds the new value. No wrap through 2^DIV_W.
- scDir change takes effect at the next advance. The current position and outputs are not disturbed.
- Reset asserted mid-run overrides everything and returns to the reset values above.

Test Plan:
1. Reset: nRst=0 for 2 clocks with scEn=1 -> scStep=0, scQuad=0, scHalf=0, scTick=0, scCycle=0.
2. Forward full cycle: scDiv=0, scDir=0, scEn raised.
   - Entry edge: scStep=1.
   - Following edges: steps 2..12, 12..1 (scQuad=1), 1..12 (scHalf=1, scQuad=2), 12..1 (scQuad=3), then scStep=1 with scQuad=0.
   - scCycle pulses exactly once, on the 47->0 edge; scTick pulses every edge after entry.
3. Prescale: scDiv=3 -> scStep holds each value 4 clocks; scTick is high 1 of every 4 clocks.
4. Reverse wrap: from reset, scDir=1, scDiv=0, enable -> entry scStep=1 (q0); next edge pos=47 gives scStep=1, scQuad=3, scHalf=1, scCycle=1; then 2, 3, ...
5. Hold and clear:
   - Drop scEn at pos=5 -> scStep=0 and pos holds.
   - Re-enable -> entry edge scStep=6.
   - Assert scClr coincident with a terminal count -> pos=0, scTick=0, scStep=1.
6. Divisor shrink: scDiv=10, run to cnt=7, set scDiv=2 -> advance on the next edge, then every 3 clocks.
